// File: rtl/pc_reg.sv
// Program-counter register for the instruction-fetch stage.
// Holds the current fetch PC and the PC it replaced, forms the next-PC
// candidate from the select mux, and tags the fetched word with static
// branch predictions. Misalignment is flagged but never corrected.
module pc_reg #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  pcmux_sel,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_prev_o,
    output logic [31:0] pc_next_o,
    output logic        illegal_sel_o,
    output logic        misaligned_o,
    output logic        br_pred_nt_o,
    output logic        br_pred_btfnt_o
);

    localparam logic [1:0] SEL_PLUS4    = 2'b00;
    localparam logic [1:0] SEL_ALU      = 2'b01;
    localparam logic [1:0] SEL_ALU_MOD2 = 2'b10;
    localparam logic [1:0] SEL_RSVD     = 2'b11;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;

    logic [31:0] pc_reg_q;
    logic [31:0] pc_prev_reg;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    // Sequential PC + 4; 32-bit arithmetic wraps 0xFFFF_FFFC back to zero.
    assign pc_plus4 = pc_reg_q + 32'd4;

    // Next-PC select; the reserved code falls back to sequential fetch.
    always_comb begin
        pc_next = pc_plus4;
        unique case (pcmux_sel)
            SEL_PLUS4:    pc_next = pc_plus4;
            SEL_ALU:      pc_next = alu_out_i;
            SEL_ALU_MOD2: pc_next = {alu_out_i[31:1], 1'b0};
            SEL_RSVD:     pc_next = pc_plus4;
            default:      pc_next = pc_plus4;
        endcase
    end

    // PC and previous-PC registers; reset wins over load, load=0 stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg_q    <= RESET_VECTOR;
            pc_prev_reg <= RESET_VECTOR;
        end else if (load) begin
            pc_prev_reg <= pc_reg_q;
            pc_reg_q    <= pc_next;
        end
    end

    // Backward-taken / forward-not-taken: the sign of the branch offset
    // (instruction bit 31) predicts taken for conditional branches only.
    always_comb begin
        br_pred_btfnt_o = 1'b0;
        if (instr_rdata_i[6:0] == OPC_BRANCH) begin
            br_pred_btfnt_o = instr_rdata_i[31];
        end
    end

    assign br_pred_nt_o  = 1'b0;
    assign pc_o          = pc_reg_q;
    assign pc_prev_o     = pc_prev_reg;
    assign pc_next_o     = pc_next;
    assign illegal_sel_o = (pcmux_sel == SEL_RSVD);
    assign misaligned_o  = |pc_reg_q[1:0];

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: a reference model pushes expected
// register values into a queue whenever an edge is driven, and the entry
// is popped and compared once the DUT has updated after that edge.
module tb_pc_reg;

    localparam logic [31:0] RV = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [1:0]  pcmux_sel;
    logic [31:0] alu_out_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] pc_prev_o;
    logic [31:0] pc_next_o;
    logic        illegal_sel_o;
    logic        misaligned_o;
    logic        br_pred_nt_o;
    logic        br_pred_btfnt_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] prev;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_prev;
    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;

    pc_reg #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .pcmux_sel       (pcmux_sel),
        .alu_out_i       (alu_out_i),
        .instr_rdata_i   (instr_rdata_i),
        .pc_o            (pc_o),
        .pc_prev_o       (pc_prev_o),
        .pc_next_o       (pc_next_o),
        .illegal_sel_o   (illegal_sel_o),
        .misaligned_o    (misaligned_o),
        .br_pred_nt_o    (br_pred_nt_o),
        .br_pred_btfnt_o (br_pred_btfnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] s, input logic [31:0] a,
                                               input logic [31:0] pc);
        case (s)
            2'b01:   return a;
            2'b10:   return a & 32'hFFFF_FFFE;
            default: return pc + 32'd4;
        endcase
    endfunction

    // Apply inputs for the coming edge and queue the expected register state.
    task automatic drive(input logic r, input logic l, input logic [1:0] s, input logic [31:0] a);
        exp_t e;
        rst       = r;
        load      = l;
        pcmux_sel = s;
        alu_out_i = a;
        if (!r) begin
            model_pc   = RV;
            model_prev = RV;
        end else if (l) begin
            model_prev = model_pc;
            model_pc   = model_next(s, a, model_pc);
        end
        e.pc   = model_pc;
        e.prev = model_prev;
        exp_q.push_back(e);
    endtask

    // Clock one edge, then pop the queued expectation and compare.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: rst=%b load=%b sel=%b alu=%h pc=%h prev=%h", txn, rst, load,
                 pcmux_sel, alu_out_i, pc_o, pc_prev_o);
        check("pc", pc_o, e.pc);
        check("pc_prev", pc_prev_o, e.prev);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; pcmux_sel = 2'b00; alu_out_i = '0; instr_rdata_i = '0;
        model_pc = 'x; model_prev = 'x;
        @(negedge clk);

        // Reset, then sequential fetch.
        drive(1'b0, 1'b0, 2'b00, 32'h0);
        tick();
        check("rst_pc", pc_o, 32'h60);
        check("rst_prev", pc_prev_o, 32'h60);
        check("rst_next", pc_next_o, 32'h64);
        check("rst_misal", {31'b0, misaligned_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b00, 32'h0);
            tick();
        end
        check("seq_pc", pc_o, 32'h6C);
        check("seq_prev", pc_prev_o, 32'h68);

        // Stall with a redirect presented: nothing moves.
        drive(1'b1, 1'b0, 2'b01, 32'h1234);
        #1 check("stall_next0", pc_next_o, 32'h1234);
        tick();
        drive(1'b1, 1'b0, 2'b01, 32'h1234);
        tick();
        check("stall_pc", pc_o, 32'h6C);
        check("stall_next1", pc_next_o, 32'h1234);
        check("stall_illegal", {31'b0, illegal_sel_o}, 32'd0);

        // JALR clears bit 0 only; then a plain aligned redirect.
        drive(1'b1, 1'b1, 2'b10, 32'h0000_2003);
        #1 check("jalr_next", pc_next_o, 32'h2002);
        tick();
        check("jalr_pc", pc_o, 32'h2002);
        check("jalr_misal", {31'b0, misaligned_o}, 32'd1);
        drive(1'b1, 1'b1, 2'b01, 32'h0000_4000);
        tick();
        check("jmp_pc", pc_o, 32'h4000);
        check("jmp_misal", {31'b0, misaligned_o}, 32'd0);

        // Wrap through the reserved select.
        drive(1'b1, 1'b1, 2'b01, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b1, 2'b11, 32'h1111_1111);
        #1 check("rsvd_illegal", {31'b0, illegal_sel_o}, 32'd1);
        check("rsvd_next", pc_next_o, 32'h0);
        tick();
        check("wrap_pc", pc_o, 32'h0);
        check("wrap_prev", pc_prev_o, 32'hFFFF_FFFC);

        // Reset overrides a pending load.
        drive(1'b0, 1'b1, 2'b01, 32'h8000);
        tick();
        check("rstpri_pc", pc_o, 32'h60);
        check("rstpri_prev", pc_prev_o, 32'h60);

        // Random traffic against the model.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            #1 check("rnd_next", pc_next_o, model_next(pcmux_sel, alu_out_i, pc_o));
            check("rnd_illegal", {31'b0, illegal_sel_o}, {31'b0, pcmux_sel == 2'b11});
            tick();
            check("rnd_misal", {31'b0, misaligned_o}, {31'b0, |model_pc[1:0]});
        end

        // Static prediction.
        instr_rdata_i = 32'hFE00_0EE3;
        #1 check("btfnt_back", {31'b0, br_pred_btfnt_o}, 32'd1);
        check("nt_back", {31'b0, br_pred_nt_o}, 32'd0);
        instr_rdata_i = 32'h0000_0463;
        #1 check("btfnt_fwd", {31'b0, br_pred_btfnt_o}, 32'd0);
        check("nt_fwd", {31'b0, br_pred_nt_o}, 32'd0);
        instr_rdata_i = 32'h8000_006F;
        #1 check("btfnt_jal", {31'b0, br_pred_btfnt_o}, 32'd0);
        check("nt_jal", {31'b0, br_pred_nt_o}, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
# pc_reg

The program-counter register of the instruction-fetch stage: it holds the current fetch PC, computes the next-PC candidate, and annotates the fetched instruction with static branch predictions. It sits at the head of the pipeline. It feeds the instruction-memory address and the IF/ID pipeline register. Writes are gated by the hazard unit's PC-write enable.

## Interface
Clocking is fixed: one clock (`clk`) and one reset (`rst`). `rst` is synchronous and active-low.

Parameters:
- `RESET_VECTOR`, default 32'h0000_0060: PC value loaded by reset.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `load` in 1: PC write enable; 0 stalls the PC.
- `pcmux_sel` in 2: next-PC select. 2'b00 = pc_plus4, 2'b01 = alu_out, 2'b10 = alu_mod2, 2'b11 = reserved.
- `alu_out_i` in 32: branch/jump target from EX.
- `instr_rdata_i` in 32: instruction word returned for the current `pc_o`.
- `pc_o` out 32: current PC (registered).
- `pc_prev_o` out 32: PC value held before the most recent load (registered).
- `pc_next_o` out 32: combinational next-PC candidate.
- `illegal_sel_o` out 1: combinational; 1 when `pcmux_sel` == 2'b11.
- `misaligned_o` out 1: combinational; |`pc_o`[1:0].
- `br_pred_nt_o` out 1: static not-taken prediction; constant 0.
- `br_pred_btfnt_o` out 1: static backward-taken/forward-not-taken prediction.

## Operation
Next-PC mux (combinational, 32-bit, wraps modulo 2^32):
- pc_plus4: `pc_o` + 4. 32'hFFFF_FFFC wraps to 0.
- alu_out: `alu_out_i` unchanged.
- alu_mod2: `alu_out_i` with bit 0 cleared (JALR rule). Bit 1 is not touched.
- reserved (2'b11): same as pc_plus4, and `illegal_sel_o` = 1.

Register update (rising edge of `clk`):
- `rst` = 0: `pc_o` ← `RESET_VECTOR` and `pc_prev_o` ← `RESET_VECTOR`. This takes priority over `load`.
- `rst` = 1 and `load` = 1: `pc_prev_o` ← `pc_o`, then `pc_o` ← `pc_next_o`.
- `rst` = 1 and `load` = 0: both registers hold.

Static prediction (combinational from `instr_rdata_i`):
- `br_pred_btfnt_o` = `instr_rdata_i`[31] when `instr_rdata_i`[6:0] == 7'b1100011 (branch opcode); otherwise 0.
- `br_pred_nt_o` = 0 always.

Misalignment:
- `misaligned_o` is only reported. The register never corrects or blocks a misaligned value.

## Timing
- `pc_o` and `pc_prev_o` have one-cycle latency from the `load`/`pcmux_sel` sampled at the edge.
- `pc_next_o`, `illegal_sel_o`, `misaligned_o` and both prediction outputs are zero-latency combinational.
- Output values after the reset edge:
  - `pc_o` = `pc_prev_o` = `RESET_VECTOR`.
  - `pc_next_o` = `RESET_VECTOR` + 4 when `pcmux_sel` = 00.
  - `misaligned_o` = |`RESET_VECTOR`[1:0] (0 for the default).
  - Prediction outputs depend only on `instr_rdata_i`.
- No asynchronous behaviour. `rst` asserted mid-stream overrides any pending load on that same edge. Release takes effect at the first edge with `rst` = 1.
- Before the first reset edge, register contents are undefined.
- A `load` held high on consecutive edges advances the PC every cycle. There is no handshake.
- When `rst` = 1 and `load` = 0, `pcmux_sel` and `alu_out_i` have no effect on state.

## Test plan
- Reset then sequential fetch: `rst` = 0 for 1 edge, then `rst` = 1, `load` = 1, sel = 00 for 3 edges -> `pc_o` goes 0x60, 0x64, 0x68, 0x6C; `pc_prev_o` lags `pc_o` by one value.
- Stall: `load` = 0 for 2 edges with sel = 01 and `alu_out_i` = 0x1234 -> `pc_o` holds 0x6C; `pc_next_o` = 0x1234 throughout.
- Redirect/JALR: `load` = 1, sel = 10, `alu_out_i` = 0x0000_2003 -> `pc_o` = 0x2002 and `misaligned_o` = 1. Then sel = 01, `alu_out_i` = 0x0000_4000 -> `pc_o` = 0x4000 and `misaligned_o` = 0.
- Wrap and illegal select: with `pc_o` = 0xFFFF_FFFC, sel = 11, `load` = 1 -> `illegal_sel_o` = 1 before the edge; `pc_o` = 0x0000_0000 after it.
- Reset priority: `rst` = 0 with `load` = 1, sel = 01, `alu_out_i` = 0x8000 -> `pc_o` = 0x60, not 0x8000.
- Prediction:
  - `instr_rdata_i` = 0xFE00_0EE3 (backward BEQ) -> `br_pred_btfnt_o` = 1.
  - `instr_rdata_i` = 0x0000_0463 (forward BEQ) -> `br_pred_btfnt_o` = 0.
  - `instr_rdata_i` = 0x8000_006F (JAL, bit 31 set) -> `br_pred_btfnt_o` = 0.
  - `br_pred_nt_o` = 0 in all three cases.
